nios2_mul_result_stage: RTL and testbench
=========================================

Name: nios2_mul_result_stage

Overview:
- Downstream consumer of the 16x16 partial-product multiply cell in the Nios II integer pipeline.
- Takes the three registered partial products at M stage: p1 = lo*lo, p2 = src1_lo*src2_hi, p3 = src1_hi*src2_lo.
- Reduces them to the low 32 bits of the 32x32 product over a two-register pipeline (M→A→W).
- Delivers the result, a destination-register tag and a valid flag to writeback/forwarding.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside the product.
- PART_W, 32, width of each partial-product input; the result width equals PART_W.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- M_en  input  1  pipeline advance enable; all stage registers load only when high
- M_kill  input  1  flush of the M and A stages (exception/branch mispredict)
- M_mul_valid  input  1  the M-stage instruction is a MUL/MULI
- M_dst_regnum  input  TAG_W  destination register of the M-stage instruction
- M_mul_cell_p1  input  PART_W  src1[15:0]*src2[15:0]
- M_mul_cell_p2  input  PART_W  src1[15:0]*src2[31:16]
- M_mul_cell_p3  input  PART_W  src1[31:16]*src2[15:0]
- W_mul_result  output  PART_W  low 32 bits of src1*src2
- W_mul_valid  output  1  W_mul_result/W_dst_regnum are meaningful this cycle
- W_dst_regnum  output  TAG_W  tag of the W-stage result
- mul_busy  output  1  a multiply is in the A or W stage (valid bit set)

Behaviour:
- Reset (asynchronous, active-high): all valid bits, data and tag registers to 0. W_mul_result=0, W_mul_valid=0, W_dst_regnum=0, mul_busy=0.
- Stage A register (loads on M_en):
  - A_p1 <= M_mul_cell_p1.
  - A_cross <= (M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0]) mod 2^16; the upper halves of p2/p3 and the carry are discarded.
  - A_tag <= M_dst_regnum.
  - A_valid <= M_mul_valid & ~M_kill.
- Stage W register (loads on M_en):
  - W_mul_result <= (A_p1 + {A_cross,16'h0}) mod 2^32; the carry out of bit 31 is dropped.
  - W_dst_regnum <= A_tag.
  - W_mul_valid <= A_valid & ~M_kill.
- Latency: a multiply presented with M_en high appears on W outputs after exactly two M_en-high edges. Stalled cycles (M_en low) add no latency and hold every register, valid bits included.
- M_kill is honoured only when M_en is high:
  - clears the incoming and A-stage valids;
  - the data registers still load (contents are don't-care);
  - a result already in W is not killed.
- Back-to-back multiplies on consecutive M_en cycles are fully pipelined, with no bubbles.
- Simultaneous M_kill, M_en and M_mul_valid: kill wins; no valid is created.
- mul_busy = A_valid | W_mul_valid.
- No other state; the block has no state machine beyond the two pipeline valids.

Optional Feature:
- Macro: NIOS2_MUL_OUT_REG_EN.
- Defined: a third register stage (W→W2, same enable/reset rules, not affected by M_kill) is inserted after the W register. Latency becomes 3 advances; mul_busy also ORs in the extra valid.
- Undefined: 2-advance latency as above.

Decomposition:
- Shared package nios2_mul_pkg holds:
  - PART_W/TAG_W default constants;
  - the half-word width constant (16);
  - a packed struct for a stage payload {valid, tag, data}.
- Natural sub-module: nios2_mul_pipe_reg, one enable-gated, killable, async-reset stage register used for A, W and the optional extra stage.

Test Plan:
- src 0x00010002 x 0x00030004 → p1=8, p2=6, p3=4, M_en held high → W_mul_result=0x000A0008, W_mul_valid=1 two cycles later, tag preserved.
- 0xFFFFFFFF x 0xFFFFFFFF → p1=p2=p3=0xFFFE0001 → W_mul_result=0x00000001 (cross and final carries dropped).
- Three back-to-back multiplies with tags 1,2,3 → results on three consecutive cycles, in order, with the correct tags.
- Stall: issue a multiply, then drop M_en for 4 cycles after the first advance → all outputs frozen; result appears on the second M_en-high edge.
- M_kill with M_en high while a multiply is in A and another is in W → W result stays valid; the A one never reaches W_mul_valid=1.
- Reset asserted mid-flight with two multiplies in A/W → all outputs 0 immediately (asynchronously); no valid after release.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// Shared constants, stage payload type and cross-term helper for the
// Nios II multiply result stage (optional macro: NIOS2_MUL_OUT_REG_EN).
package nios2_mul_pkg;

  localparam int PART_W_DEF = 32;
  localparam int TAG_W_DEF  = 5;
  localparam int HALF_W     = 16;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [PART_W_DEF-1:0] data;
  } mul_stage_t;

  // Only the low half-words of the cross products reach bits [31:16] of the
  // 32-bit result, so the sum is kept modulo 2^HALF_W.
  function automatic logic [HALF_W-1:0] cross_sum(input logic [HALF_W-1:0] a,
                                                   input logic [HALF_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/nios2_mul_pipe_reg.sv
// One enable-gated, killable pipeline stage register with asynchronous reset.
// Holds every field (valid included) while en is low; kill only acts with en.
module nios2_mul_pipe_reg
  import nios2_mul_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = PART_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              kill,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [TAG_W-1:0]  tag_d, tag_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid & ~kill;
      tag_d   = in_tag;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign data  = data_q;

endmodule

// File: rtl/nios2_mul_result_stage.sv
// Reduces three 16x16 partial products to the low word of a 32x32 product
// over M->A->W. Define NIOS2_MUL_OUT_REG_EN to add an output stage (W->W2).
module nios2_mul_result_stage
  import nios2_mul_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int PART_W = PART_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M_en,
  input  logic              M_kill,
  input  logic              M_mul_valid,
  input  logic [TAG_W-1:0]  M_dst_regnum,
  input  logic [PART_W-1:0] M_mul_cell_p1,
  input  logic [PART_W-1:0] M_mul_cell_p2,
  input  logic [PART_W-1:0] M_mul_cell_p3,
  output logic [PART_W-1:0] W_mul_result,
  output logic              W_mul_valid,
  output logic [TAG_W-1:0]  W_dst_regnum,
  output logic              mul_busy
);

  logic [HALF_W-1:0]        m_cross;
  logic                     a_valid;
  logic [TAG_W-1:0]         a_tag;
  logic [PART_W+HALF_W-1:0] a_data;
  logic [PART_W-1:0]        a_p1;
  logic [HALF_W-1:0]        a_cross;
  logic [PART_W-1:0]        w_sum;
  logic                     w_valid;
  logic [TAG_W-1:0]         w_tag;
  logic [PART_W-1:0]        w_data;
  logic                     unused_hi;

  // Upper halves of the cross products only affect bits above the result word.
  assign unused_hi = ^{M_mul_cell_p2[PART_W-1:HALF_W], M_mul_cell_p3[PART_W-1:HALF_W]};

  assign m_cross = cross_sum(M_mul_cell_p2[HALF_W-1:0], M_mul_cell_p3[HALF_W-1:0]);

  nios2_mul_pipe_reg #(.TAG_W(TAG_W), .DATA_W(PART_W + HALF_W)) u_stage_a (
    .clk      (clk),
    .rst      (reset),
    .en       (M_en),
    .kill     (M_kill),
    .in_valid (M_mul_valid),
    .in_tag   (M_dst_regnum),
    .in_data  ({m_cross, M_mul_cell_p1}),
    .valid    (a_valid),
    .tag      (a_tag),
    .data     (a_data)
  );

  assign a_p1    = a_data[PART_W-1:0];
  assign a_cross = a_data[PART_W +: HALF_W];
  assign w_sum   = a_p1 + PART_W'({a_cross, {HALF_W{1'b0}}});

  nios2_mul_pipe_reg #(.TAG_W(TAG_W), .DATA_W(PART_W)) u_stage_w (
    .clk      (clk),
    .rst      (reset),
    .en       (M_en),
    .kill     (M_kill),
    .in_valid (a_valid),
    .in_tag   (a_tag),
    .in_data  (w_sum),
    .valid    (w_valid),
    .tag      (w_tag),
    .data     (w_data)
  );

`ifdef NIOS2_MUL_OUT_REG_EN
  logic              w2_valid;
  logic [TAG_W-1:0]  w2_tag;
  logic [PART_W-1:0] w2_data;

  // The result has already left the flushable stages, so it is never killed.
  nios2_mul_pipe_reg #(.TAG_W(TAG_W), .DATA_W(PART_W)) u_stage_w2 (
    .clk      (clk),
    .rst      (reset),
    .en       (M_en),
    .kill     (1'b0),
    .in_valid (w_valid),
    .in_tag   (w_tag),
    .in_data  (w_data),
    .valid    (w2_valid),
    .tag      (w2_tag),
    .data     (w2_data)
  );

  assign W_mul_result = w2_data;
  assign W_mul_valid  = w2_valid;
  assign W_dst_regnum = w2_tag;
  assign mul_busy     = a_valid | w_valid | w2_valid;
`else
  assign W_mul_result = w_data;
  assign W_mul_valid  = w_valid;
  assign W_dst_regnum = w_tag;
  assign mul_busy     = a_valid | w_valid;
`endif

endmodule

// File: tb/tb_nios2_mul_result_stage.sv
// Directed, table-driven bench for nios2_mul_result_stage: pipelined vectors
// followed by stall, kill and mid-flight reset sequences.
module tb_nios2_mul_result_stage;

`ifdef NIOS2_MUL_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 9;

  typedef struct {
    logic        vld;
    logic [4:0]  tag;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        M_en = 1'b0;
  logic        M_kill = 1'b0;
  logic        M_mul_valid = 1'b0;
  logic [4:0]  M_dst_regnum = '0;
  logic [31:0] M_mul_cell_p1 = '0;
  logic [31:0] M_mul_cell_p2 = '0;
  logic [31:0] M_mul_cell_p3 = '0;
  logic [31:0] W_mul_result;
  logic        W_mul_valid;
  logic [4:0]  W_dst_regnum;
  logic        mul_busy;

  int checks = 0;
  int failures = 0;
  vec_t vecs[NV];
  logic [31:0] exp_q[$];
  logic [4:0]  tag_q[$];

  nios2_mul_result_stage dut (
    .clk           (clk),
    .reset         (reset),
    .M_en          (M_en),
    .M_kill        (M_kill),
    .M_mul_valid   (M_mul_valid),
    .M_dst_regnum  (M_dst_regnum),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid),
    .W_dst_regnum  (W_dst_regnum),
    .mul_busy      (mul_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic kill, input logic vld, input logic [4:0] tag,
                       input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    M_en         = en;
    M_kill       = kill;
    M_mul_valid  = vld;
    M_dst_regnum = tag;
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic check_zero(input string tag_name);
    check({tag_name, "_result"}, W_mul_result, 32'h0);
    check({tag_name, "_valid"}, 32'(W_mul_valid), 32'h0);
    check({tag_name, "_tag"}, 32'(W_dst_regnum), 32'h0);
    check({tag_name, "_busy"}, 32'(mul_busy), 32'h0);
  endtask

  initial begin
    int seen_x, seen_y, seen_z;
    logic exp_busy;

    //            vld   tag    p1            p2            p3            expected
    vecs[0] = '{1'b1, 5'd7,  32'h0000_0008, 32'h0000_0006, 32'h0000_0004, 32'h000A_0008};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 32'h0000_0001};
    vecs[2] = '{1'b1, 5'd4,  32'h0000_1234, 32'h1234_8000, 32'hABCD_8000, 32'h0000_1234};
    vecs[3] = '{1'b1, 5'd12, 32'h0000_0015, 32'h0000_000F, 32'h0000_000E, 32'h001D_0015};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFE_0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFE_0001};
    vecs[5] = '{1'b1, 5'd1,  32'h0005_6780, 32'h0000_0000, 32'h0001_2340, 32'h2345_6780};
    vecs[6] = '{1'b1, 5'd2,  32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 32'h0000_0009};
    vecs[7] = '{1'b1, 5'd3,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{1'b0, 5'd9,  32'h0000_0077, 32'h0000_0011, 32'h0000_0022, 32'h0000_0000};

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    idle();

    // Back-to-back table vectors with M_en held high
    for (int i = 0; i < NV + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        check("vec_valid", 32'(W_mul_valid), 32'(vecs[i-LAT].vld));
        if (vecs[i-LAT].vld) begin
          check("vec_result", W_mul_result, exp_q.pop_front());
          check("vec_tag", 32'(W_dst_regnum), 32'(tag_q.pop_front()));
        end
      end
      exp_busy = 1'b0;
      for (int k = 1; k <= LAT; k++)
        if (i - k >= 0 && i - k < NV) exp_busy |= vecs[i-k].vld;
      check("vec_busy", 32'(mul_busy), 32'(exp_busy));
      if (i < NV) begin
        drive(1'b1, 1'b0, vecs[i].vld, vecs[i].tag, vecs[i].p1, vecs[i].p2, vecs[i].p3);
        if (vecs[i].vld) begin
          exp_q.push_back(vecs[i].exp);
          tag_q.push_back(vecs[i].tag);
        end
      end else begin
        idle();
      end
    end

    // Stall: one advance, four held cycles (with a kill that must be ignored)
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0008, 32'h0000_0006, 32'h0000_0004);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(W_mul_valid), 32'h0);
      check("stall_busy", 32'(mul_busy), 32'h1);
      if (k < 4) drive(1'b0, (k == 1), 1'b1, 5'd20, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
      else idle();
    end
    for (int a = 1; a < LAT; a++) begin
      @(negedge clk);
      if (a == LAT - 1) begin
        check("stall_res_valid", 32'(W_mul_valid), 32'h1);
        check("stall_result", W_mul_result, 32'h000A_0008);
        check("stall_tag", 32'(W_dst_regnum), 32'd4);
      end else begin
        check("stall_early_valid", 32'(W_mul_valid), 32'h0);
      end
    end

    // Kill while X sits in W and Y in A; Z arrives with kill and is dropped too
    seen_x = 0;
    seen_y = 0;
    seen_z = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0015, 32'h0000_000F, 32'h0000_000E);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0008, 32'h0000_0006, 32'h0000_0004);
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (W_mul_valid && W_dst_regnum == 5'd10) begin
        seen_x++;
        check("kill_x_result", W_mul_result, 32'h001D_0015);
      end
      if (W_mul_valid && W_dst_regnum == 5'd11) seen_y++;
      if (W_mul_valid && W_dst_regnum == 5'd12) seen_z++;
      if (c == 0) drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
      else idle();
    end
    check("kill_x_seen", 32'(seen_x), 32'd1);
    check("kill_y_seen", 32'(seen_y), 32'd0);
    check("kill_z_seen", 32'(seen_z), 32'd0);
    check("kill_busy", 32'(mul_busy), 32'h0);

    // Asynchronous reset with two multiplies in flight
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0015, 32'h0000_000F, 32'h0000_000E);
    @(negedge clk);
    M_en = 1'b0;
    check("pre_reset_busy", 32'(mul_busy), 32'h1);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int c = 0; c < LAT + 1; c++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(W_mul_valid), 32'h0);
      check("post_reset_busy", 32'(mul_busy), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
